sram_arbiter_mc: RTL

- Parametrised, N-channel successor to the two-requester SRAM controller.
- Serialises register-interface accesses and NUM_PORTS generic read/write requesters onto one ZBT SRAM port.
- Arbitration: register access has fixed top priority; ports share the remainder round-robin.
- Read data returns on a shared bus, qualified by a per-port valid; writes follow the 2-cycle ZBT write-data/tristate delay.

---
 rtl/sram_arbiter_mc.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter_mc.sv
// sram_arbiter_mc: serialises a register interface and NUM_PORTS round-robin
// requesters onto one ZBT SRAM port. Register accesses always win; ports
// share the remaining slots round-robin. Read data returns on a shared bus
// tagged by a one-hot per-port valid.
// Optional feature macro: SRAM_ARB_INIT_CLEAR_EN (zero-fill the whole SRAM
// after reset before accepting requests).
module sram_arbiter_mc #(
   parameter int NUM_PORTS       = 4,
   parameter int SRAM_ADDR_WIDTH = 19,
   parameter int SRAM_DATA_WIDTH = 72,
   parameter int RD_LATENCY      = 3,
   parameter int REG_ADDR_WIDTH  = 20,
   parameter int REG_DATA_WIDTH  = 32
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 sram_reg_req,
   input  logic                                 sram_reg_rd_wr_L,
   input  logic [REG_ADDR_WIDTH-1:0]            sram_reg_addr,
   input  logic [REG_DATA_WIDTH-1:0]            sram_reg_wr_data,
   output logic                                 sram_reg_ack,
   output logic [REG_DATA_WIDTH-1:0]            sram_reg_rd_data,
   input  logic [NUM_PORTS-1:0]                 port_req,
   input  logic [NUM_PORTS-1:0]                 port_rd_wr_L,
   input  logic [NUM_PORTS*SRAM_ADDR_WIDTH-1:0] port_addr,
   input  logic [NUM_PORTS*SRAM_DATA_WIDTH-1:0] port_wr_data,
   output logic [NUM_PORTS-1:0]                 port_ack,
   output logic [NUM_PORTS-1:0]                 port_rd_vld,
   output logic [SRAM_DATA_WIDTH-1:0]           rd_data,
   output logic [SRAM_ADDR_WIDTH-1:0]           sram_addr,
   output logic                                 sram_we,
   output logic [SRAM_DATA_WIDTH/9-1:0]         sram_bw,
   output logic [SRAM_DATA_WIDTH-1:0]           sram_wr_data,
   input  logic [SRAM_DATA_WIDTH-1:0]           sram_rd_data,
   output logic                                 sram_tri_en,
   output logic                                 enable
);

   localparam int BW       = SRAM_DATA_WIDTH / 9;
   localparam int HB       = BW / 2;
   localparam int HALF     = SRAM_DATA_WIDTH / 2;
   localparam int PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   // Tag layout: [NUM_PORTS-1:0] port read owner, then reg, reg-read, half.
   localparam int TAG_REG  = NUM_PORTS;
   localparam int TAG_RD   = NUM_PORTS + 1;
   localparam int TAG_HALF = NUM_PORTS + 2;
   localparam int TW       = NUM_PORTS + 3;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t                     state, state_next;
   logic [PW-1:0]              rr_ptr;
   logic [PW-1:0]              grant_idx, cand;
   logic                       grant_found, port_grant;
   logic                       issue_valid, issue_we;
   logic [BW-1:0]              issue_bw;
   logic [SRAM_ADDR_WIDTH-1:0] issue_addr;
   logic [SRAM_DATA_WIDTH-1:0] issue_wdata;
   logic [TW-1:0]              issue_tag;
   logic [NUM_PORTS-1:0]       issue_ack;
   logic [SRAM_ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
   logic [SRAM_DATA_WIDTH-1:0] wdata_arr [NUM_PORTS];
   logic [TW-1:0]              cmd_tag;
   logic [TW-1:0]              tag_pipe  [RD_LATENCY];
   logic [TW-1:0]              tag_tail;
   logic [1:0]                 wr_vld_pipe;
   logic [SRAM_DATA_WIDTH-1:0] wr_data_pipe [2];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
         assign addr_arr[gi]  = port_addr[gi*SRAM_ADDR_WIDTH +: SRAM_ADDR_WIDTH];
         assign wdata_arr[gi] = port_wr_data[gi*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH];
      end
   endgenerate

   assign enable = (state == ST_RUN);

`ifdef SRAM_ARB_INIT_CLEAR_EN
   logic [SRAM_ADDR_WIDTH-1:0] init_cnt;

   // Sweep address counter used only while clearing the SRAM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                init_cnt <= '0;
      else if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
   end
`endif

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_INIT;
      else        state <= state_next;
   end

   // Next state plus the command to issue: register access first, then round-robin ports.
   always_comb begin
      state_next  = state;
      issue_valid = 1'b0;
      issue_we    = 1'b1;
      issue_bw    = '1;
      issue_addr  = sram_addr;
      issue_wdata = '0;
      issue_tag   = '0;
      issue_ack   = '0;
      grant_found = 1'b0;
      grant_idx   = rr_ptr;
      cand        = '0;
      port_grant  = 1'b0;
      case (state)
         ST_INIT: begin
`ifdef SRAM_ARB_INIT_CLEAR_EN
            issue_valid = 1'b1;
            issue_we    = 1'b0;
            issue_bw    = '0;
            issue_addr  = init_cnt;
            if (init_cnt == {SRAM_ADDR_WIDTH{1'b1}}) state_next = ST_RUN;
`else
            state_next = ST_RUN;
`endif
         end
         ST_RUN: begin
            for (int k = 1; k <= NUM_PORTS; k++) begin
               cand = PW'((int'(rr_ptr) + k) % NUM_PORTS);
               if (!grant_found && port_req[cand]) begin
                  grant_found = 1'b1;
                  grant_idx   = cand;
               end
            end
            if (sram_reg_req) begin
               issue_valid        = 1'b1;
               issue_addr         = sram_reg_addr[REG_ADDR_WIDTH-1:1];
               issue_tag[TAG_REG] = 1'b1;
               issue_tag[TAG_HALF] = sram_reg_addr[0];
               if (sram_reg_rd_wr_L) begin
                  issue_tag[TAG_RD] = 1'b1;
               end else begin
                  issue_we = 1'b0;
                  if (sram_reg_addr[0]) begin
                     issue_bw = {{HB{1'b0}}, {HB{1'b1}}};
                     issue_wdata[HALF +: REG_DATA_WIDTH] = sram_reg_wr_data;
                  end else begin
                     issue_bw = {{HB{1'b1}}, {HB{1'b0}}};
                     issue_wdata[REG_DATA_WIDTH-1:0] = sram_reg_wr_data;
                  end
               end
            end else if (grant_found) begin
               port_grant           = 1'b1;
               issue_valid          = 1'b1;
               issue_addr           = addr_arr[grant_idx];
               issue_ack[grant_idx] = 1'b1;
               if (port_rd_wr_L[grant_idx]) begin
                  issue_tag[grant_idx] = 1'b1;
               end else begin
                  issue_we    = 1'b0;
                  issue_bw    = '0;
                  issue_wdata = wdata_arr[grant_idx];
               end
            end
         end
         default: state_next = ST_INIT;
      endcase
   end

   // Command register driving the SRAM pins, acks and the round-robin pointer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sram_addr <= '0;
         sram_we   <= 1'b1;
         sram_bw   <= '1;
         port_ack  <= '0;
         cmd_tag   <= '0;
         rr_ptr    <= PW'(NUM_PORTS - 1);
      end else begin
         if (issue_valid) sram_addr <= issue_addr;
         sram_we  <= issue_we;
         sram_bw  <= issue_bw;
         port_ack <= issue_ack;
         cmd_tag  <= issue_tag;
         if (port_grant) rr_ptr <= grant_idx;
      end
   end

   // Write data and tristate enable trail the write command by two cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_vld_pipe     <= '0;
         wr_data_pipe[0] <= '0;
         wr_data_pipe[1] <= '0;
         sram_tri_en     <= 1'b0;
         sram_wr_data    <= '0;
      end else begin
         wr_vld_pipe     <= {wr_vld_pipe[0], ~issue_we};
         wr_data_pipe[0] <= issue_wdata;
         wr_data_pipe[1] <= wr_data_pipe[0];
         sram_tri_en     <= wr_vld_pipe[1];
         sram_wr_data    <= wr_vld_pipe[1] ? wr_data_pipe[1] : '0;
      end
   end

   // Ownership tags follow each command until its data is on the read pins.
   generate
      for (gi = 0; gi < RD_LATENCY; gi++) begin : g_tag
         always_ff @(posedge clk or negedge reset) begin
            if (!reset)        tag_pipe[gi] <= '0;
            else if (gi == 0)  tag_pipe[gi] <= cmd_tag;
            else               tag_pipe[gi] <= tag_pipe[(gi > 0) ? gi - 1 : 0];
         end
      end
   endgenerate

   assign tag_tail = tag_pipe[RD_LATENCY-1];

   // Capture returning read data and raise the owner's valid/ack.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         port_rd_vld      <= '0;
         rd_data          <= '0;
         sram_reg_ack     <= 1'b0;
         sram_reg_rd_data <= '0;
      end else begin
         port_rd_vld  <= tag_tail[NUM_PORTS-1:0];
         sram_reg_ack <= tag_tail[TAG_REG];
         if (|tag_tail[NUM_PORTS-1:0]) rd_data <= sram_rd_data;
         if (tag_tail[TAG_REG] && tag_tail[TAG_RD])
            sram_reg_rd_data <= tag_tail[TAG_HALF] ? sram_rd_data[HALF +: REG_DATA_WIDTH]
                                                   : sram_rd_data[REG_DATA_WIDTH-1:0];
      end
   end

endmodule
